// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   op_e          - MDU operation encodings carried on the 4-bit op bus
//   state_e       - sequencer states
//   MULT_LAT_DEF  - default busy cycles for mult/multu (and madd family)
//   DIV_LAT_DEF   - default busy cycles for div/divu
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub (ops 7-9).
package mdu_pkg;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Ops that occupy the unit for the multiply latency.
  function automatic logic is_mul_op(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational result generator for the MDU.
//   op            - latched operation code
//   a, b          - latched operands (rs, rt)
//   hi_in, lo_in  - current HI/LO (accumulator input, pass-through otherwise)
//   hi_res/lo_res - new HI/LO value for the op
// Macro MDU_MADD_EN adds the madd/maddu/msub accumulate paths.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic [63:0] prod_s, prod_u, acc;
  logic [31:0] a_abs, b_abs, q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign acc    = {hi_in, lo_in};
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide done on magnitudes: avoids the INT_MIN/-1 overflow case
  // (which falls out as quotient 0x80000000, remainder 0) and gives
  // truncation toward zero with the remainder taking the dividend's sign.
  assign a_abs = a[31] ? (32'd0 - a) : a;
  assign b_abs = b[31] ? (32'd0 - b) : b;
  assign q_mag = a_abs / b_abs;
  assign r_mag = a_abs % b_abs;
  assign q_s   = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = a[31] ? (32'd0 - r_mag) : r_mag;
  assign q_u   = a / b;
  assign r_u   = a % b;

  always_comb begin
    hi_res = hi_in;
    lo_res = lo_in;
    case (op)
      OP_MULT:  {hi_res, lo_res} = prod_s;
      OP_MULTU: {hi_res, lo_res} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          hi_res = a;
          lo_res = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
          hi_res = r_s;
          lo_res = q_s;
        end else begin
          hi_res = r_u;
          lo_res = q_u;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {hi_res, lo_res} = acc + prod_s;
      OP_MADDU: {hi_res, lo_res} = acc + prod_u;
      OP_MSUB:  {hi_res, lo_res} = acc - prod_s;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide unit with HI/LO registers.
//   clk, reset      - clock, synchronous active-high reset
//   start, op       - E-stage MDU instruction valid and its operation
//   rs_val, rt_val  - operands (rs_val is also mthi/mtlo write data)
//   flush           - cancels the E-stage instruction
//   md_use, stall   - D-stage MDU/mfhi/mflo use and resulting freeze request
//   rd_sel, mdur    - read select (0 LO, 1 HI) and read data
//   busy            - multi-cycle operation in progress
//   hi_o, lo_o      - architectural HI/LO
// Macro MDU_MADD_EN enables madd/maddu/msub; otherwise ops 7-9 are no-ops.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        md_use,
  input  logic        rd_sel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] mdur,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      rs_q, rs_d, rt_q, rt_d;
  logic [31:0]      arith_hi, arith_lo;

  mdu_arith u_arith (
    .op     (op_q),
    .a      (rs_q),
    .b      (rt_q),
    .hi_in  (hi_q),
    .lo_in  (lo_q),
    .hi_res (arith_hi),
    .lo_res (arith_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          if (is_mul_op(op) || is_div_op(op)) begin
            state_d = ST_BUSY;
            cnt_d   = is_div_op(op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            op_d    = op;
            rs_d    = rs_val;
            rt_d    = rt_val;
          end else if (op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      ST_BUSY: begin
        // Counter reaches 1 in the last busy cycle; results commit on its closing edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = arith_hi;
          lo_d    = arith_lo;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy  = (state_q == ST_BUSY);
  assign stall = md_use & (busy | (start & ~flush & (op != 4'd0)));
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;
  assign mdur  = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset, start, flush, md_use, rd_sel;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall;
  logic [31:0] mdur, hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi, m_lo;

  mdu_seq #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .md_use (md_use),
    .rd_sel (rd_sel),
    .busy   (busy),
    .stall  (stall),
    .mdur   (mdur),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: 64-bit integer arithmetic straight from the op definitions.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {hi, lo};
    case (o)
      4'd1: return sa * sb;
      4'd2: return ua * ub;
      4'd3, 4'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 4'd3) begin q = sa / sb; r = sa % sb; end
        else begin q = ua / ub; r = ua % ub; end
        return {r[31:0], q[31:0]};
      end
      4'd5: return {a, lo};
      4'd6: return {hi, a};
`ifdef MDU_MADD_EN
      4'd7: return acc + sa * sb;
      4'd8: return acc + ua * ub;
      4'd9: return acc - sa * sb;
`endif
      default: return acc;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] o, input logic fl);
    if (fl) return 0;
    if (o >= 4'd1 && o <= 4'd2) return MULT_LAT;
    if (o >= 4'd3 && o <= 4'd4) return DIV_LAT;
`ifdef MDU_MADD_EN
    if (o >= 4'd7 && o <= 4'd9) return MULT_LAT;
`endif
    return 0;
  endfunction

  // Issues one op with md_use held, scrambles inputs while busy, and returns
  // the observed busy length and final HI/LO.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic fl, output int lat, output logic [31:0] hi,
                        output logic [31:0] lo);
    start = 1'b1; op = o; rs_val = a; rt_val = b; flush = fl; md_use = 1'b1;
    #1;
    chk("stall_start", stall, !fl && (o != 4'd0));
    tick();
    start = 1'b0; flush = 1'b0;
    lat = 0;
    while (busy && lat < DIV_LAT + 5) begin
      chk("stall_busy", stall, 1'b1);
      op = 4'($urandom); rs_val = $urandom; rt_val = $urandom;
      flush = 1'($urandom);
      lat++;
      tick();
    end
    flush = 1'b0;
    op = 4'd0;
    #1;
    chk("stall_idle", stall, 1'b0);
    hi = hi_o;
    lo = lo_o;
  endtask

  task automatic check_read(input logic [31:0] ehi, input logic [31:0] elo);
    rd_sel = 1'b0; #1;
    chk("mdur_lo", mdur, elo);
    rd_sel = 1'b1; #1;
    chk("mdur_hi", mdur, ehi);
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    logic [31:0] hi, lo, a, b;
    logic [3:0] o;
    logic fl;
    logic [63:0] e;

    reset = 1'b1; start = 1'b0; flush = 1'b0; md_use = 1'b0; rd_sel = 1'b0;
    op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
    tick(); tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_hi", hi_o, 32'd0);
    chk("reset_lo", lo_o, 32'd0);
    reset = 1'b0;
    m_hi = 0; m_lo = 0;

    vecs.push_back('{4'd1, 32'hFFFF_FFFD, 32'd7,         MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{4'd4, 32'd100,       32'd7,         DIV_LAT,  32'd2,         32'd14});
    vecs.push_back('{4'd3, 32'hFFFF_FFF9, 32'd2,         DIV_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{4'd3, 32'd5,         32'd0,         DIV_LAT,  32'd5,         32'hFFFF_FFFF});
    vecs.push_back('{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,  32'd0,         32'h8000_0000});
    vecs.push_back('{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_LAT, 32'hFFFF_FFFE, 32'd1});
    vecs.push_back('{4'd4, 32'hFFFF_FFFF, 32'd0,         DIV_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{4'd3, 32'd7,         32'hFFFF_FFFE, DIV_LAT,  32'd1,         32'hFFFF_FFFD});
    vecs.push_back('{4'd5, 32'h1234,      32'd0,         0,        32'h1234,      32'hFFFF_FFFD});
    vecs.push_back('{4'd6, 32'hABCD,      32'd0,         0,        32'h1234,      32'hABCD});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, lat, hi, lo);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      m_hi = vecs[i].hi; m_lo = vecs[i].lo;
    end
    check_read(m_hi, m_lo);

    // start with flush: nothing happens
    run_op(4'd1, 32'd9, 32'd9, 1'b1, lat, hi, lo);
    chk("flush_lat", lat, 0);
    chk("flush_hi", hi, m_hi);
    chk("flush_lo", lo, m_lo);

    // reset in the 3rd busy cycle of a div
    start = 1'b1; op = 4'd3; rs_val = 32'd50; rt_val = 32'd3; md_use = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_hi", hi_o, 32'd0);
    chk("midrst_lo", lo_o, 32'd0);
    m_hi = 0; m_lo = 0;

    // reset wins over start in the same cycle
    reset = 1'b1; start = 1'b1; op = 4'd1; rs_val = 32'd3; rt_val = 32'd3;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("rstprio_busy", busy, 1'b0);
    tick();
    chk("rstprio_busy2", busy, 1'b0);
    chk("rstprio_lo", lo_o, 32'd0);

    // madd 2*3 onto HI=0, LO=FFFFFFFF
    run_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, lat, hi, lo);
    m_lo = 32'hFFFF_FFFF;
    run_op(4'd7, 32'd2, 32'd3, 1'b0, lat, hi, lo);
`ifdef MDU_MADD_EN
    chk("madd_lat", lat, MULT_LAT);
    chk("madd_hi", hi, 32'd1);
    chk("madd_lo", lo, 32'd5);
    m_hi = 32'd1; m_lo = 32'd5;
`else
    chk("madd_lat", lat, 0);
    chk("madd_hi", hi, 32'd0);
    chk("madd_lo", lo, 32'hFFFF_FFFF);
`endif

    // randomized ops against the model
    for (int n = 0; n < 60; n++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
        3: b = 32'($signed(-$urandom_range(1, 20)));
        default: ;
      endcase
      fl = ($urandom_range(0, 9) == 0);
      e = fl ? {m_hi, m_lo} : model(o, a, b, m_hi, m_lo);
      run_op(o, a, b, fl, lat, hi, lo);
      chk($sformatf("rnd%0d_op%0d_lat", n, o), lat, model_lat(o, fl));
      chk($sformatf("rnd%0d_op%0d_hilo", n, o), {hi, lo}, e);
      m_hi = e[63:32]; m_lo = e[31:0];
    end
    check_read(m_hi, m_lo);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter MULT_LAT, default 5, is the number of busy cycles for mult/multu.
REQ-002 Parameter DIV_LAT, default 10, is the number of busy cycles for div/divu.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  E-stage MDU instruction valid this cycle.
REQ-006 op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub.
REQ-007 rs_val  input  32  first operand, or write data for mthi/mtlo.
REQ-008 rt_val  input  32  second operand.
REQ-009 flush  input  1  exception/interrupt cancel for the E-stage instruction.
REQ-010 md_use  input  1  D-stage instruction is an MDU op or mfhi/mflo.
REQ-011 rd_sel  input  1  read select: 0 selects LO, 1 selects HI.
REQ-012 busy  output  1  a multi-cycle operation is in progress.
REQ-013 stall  output  1  request to freeze the D stage.
REQ-014 mdur  output  32  HI or LO per rd_sel; feeds MDUR_i of the writeback stage.
REQ-015 hi_o, lo_o  output  32 each  current architectural HI and LO.

Function
REQ-016 States: IDLE and BUSY, with a down-counter sized to hold DIV_LAT.
REQ-017 IDLE -> BUSY when start=1, flush=0, and op is in 1-4 or (with the macro) 7-9; the counter loads MULT_LAT or DIV_LAT.
REQ-018 start at cycle t -> busy=1 for cycles t+1..t+LAT; HI/LO update on the edge closing cycle t+LAT; busy=0 from t+LAT+1.
REQ-019 The operands and op SHALL be latched at start; later changes on the inputs are ignored.
REQ-020 mult: {HI,LO} = signed rs*rt, 64-bit. multu: the same product, unsigned.
REQ-021 div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend. divu: the same, unsigned.
REQ-022 Divide by zero: LO = 32'hFFFFFFFF, HI = rs; the operation keeps the full DIV_LAT latency.
REQ-023 Signed 32'h80000000 / -1: LO = 32'h80000000, HI = 0.
REQ-024 mthi/mtlo with flush=0: single-cycle write of rs_val at the next edge; busy is not asserted.
REQ-025 start with flush=1 SHALL have no effect.
REQ-026 flush during BUSY does not abort the operation in flight.
REQ-027 start while BUSY SHALL be ignored; upstream stall logic guarantees this does not occur.
REQ-028 stall = md_use & (busy | (start & ~flush & op!=0)), combinational.
REQ-029 mdur and hi_o/lo_o are combinational from the HI/LO registers; there is no internal bypass of results still pending.
REQ-030 op 0 and undefined codes are no-ops.

Reset
REQ-031 reset SHALL set state=IDLE, counter=0, HI=0, LO=0, busy=0.
REQ-032 reset asserted mid-operation SHALL discard the operation; HI/LO become 0.
REQ-033 reset has priority over start and flush in the same cycle.

Configuration
REQ-034 Macro MDU_MADD_EN: when defined, ops 7-9 add or subtract the product into {HI,LO} modulo 2^64 with MULT_LAT latency (madd: signed add; maddu: unsigned add; msub: signed subtract).
REQ-035 When MDU_MADD_EN is undefined, ops 7-9 are no-ops: no busy, no HI/LO change.

Structure
REQ-036 Op encodings, the state enum and the default latency constants SHALL live in the shared package mdu_pkg.
REQ-037 One sub-module, mdu_arith, SHALL hold the combinational 64-bit product, quotient/remainder and accumulate logic; mdu_seq holds the state and HI/LO.

Verification
REQ-038 mult rs=-3, rt=7 -> busy for 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
REQ-039 divu rs=100, rt=7 -> busy for 10 cycles, then LO=14, HI=2; div rs=-7, rt=2 -> LO=-3, HI=-1.
REQ-040 div rs=5, rt=0 -> LO=32'hFFFFFFFF, HI=5 after 10 cycles.
REQ-041 start mult with md_use=1 held -> stall=1 in the start cycle and every busy cycle, stall=0 once busy drops; mflo then reads the new LO.
REQ-042 start together with flush=1 -> busy stays 0 and HI/LO unchanged; mthi rs=32'h1234 -> hi_o=32'h1234 next cycle.
REQ-043 reset at the 3rd busy cycle of a div -> busy=0, HI=LO=0 next cycle; with MDU_MADD_EN, madd 2*3 on HI=0, LO=32'hFFFFFFFF -> HI=1, LO=5.
